// File: rtl/mem_bus_sequencer.sv
// mem_bus_sequencer: turns write/read burst commands into the byte-level
// memory bus protocol (0xFF write header / 0x00 read header, then payload
// or 0x01 read strobes) and captures read bytes while the memory owns the bus.
module mem_bus_sequencer #(
  parameter int MAX_LEN = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_write_i,
  input  logic [2:0] cmd_len_i,
  input  logic [7:0] wr_data_i,
  input  logic       wr_valid_i,
  output logic       wr_ready_o,
  output logic [7:0] rd_data_o,
  output logic       rd_valid_o,
  output logic       done_o,
  output logic       err_o,
  inout  wire  [7:0] mem_data_io,
  output logic       mem_tx_oe_o
);

  localparam logic [2:0] MaxLenL = 3'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    WDATA = 3'd2,
    RSTB  = 3'd3,
    RCAP  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t     state_q;
  logic       write_q;
  logic [2:0] len_q;
  logic [2:0] beat_q;
  logic [2:0] beat_d;
  logic [7:0] rd_data_q;
  logic       rd_valid_q;
  logic       done_q;
  logic       err_q;
  logic       oe_q;
  logic       cmd_ready_q;
  logic       wr_ready_q;
  logic       len_bad;
  logic       wr_legal;
  logic [7:0] bus_drive;

  // Beat increment and legality decodes shared by the FSM and bus mux.
  always_comb begin
    beat_d   = beat_q + 3'd1;
    len_bad  = (cmd_len_i == 3'd0) || (cmd_len_i > MaxLenL);
    // 0x00 and 0xFF are protocol control values and cannot be payload.
    wr_legal = wr_valid_i && (wr_data_i != 8'h00) && (wr_data_i != 8'hFF);
  end

  // Burst sequencing FSM; all handshake and status outputs are registered here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      len_q       <= 3'd0;
      beat_q      <= 3'd0;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      oe_q        <= 1'b0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            write_q <= cmd_write_i;
            len_q   <= cmd_len_i;
            beat_q  <= 3'd0;
            if (len_bad) begin
              // Rejected command: flag it and never touch the bus.
              err_q <= 1'b1;
            end else begin
              state_q     <= HDR;
              cmd_ready_q <= 1'b0;
            end
          end
        end
        HDR: begin
          if (write_q) begin
            state_q    <= WDATA;
            wr_ready_q <= 1'b1;
          end else begin
            state_q <= RSTB;
          end
        end
        WDATA: begin
          if (wr_legal) begin
            beat_q <= beat_d;
            if (beat_d == len_q) begin
              state_q    <= DONE;
              wr_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end else if (wr_valid_i) begin
            // Illegal byte is consumed but not counted; bus showed 0xFF.
            err_q <= 1'b1;
          end
        end
        RSTB: begin
          state_q <= RCAP;
          oe_q    <= 1'b1;
        end
        RCAP: begin
          rd_data_q  <= mem_data_io;
          rd_valid_q <= 1'b1;
          beat_q     <= beat_d;
          oe_q       <= 1'b0;
          if (beat_d == len_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= RSTB;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          wr_ready_q  <= 1'b0;
          oe_q        <= 1'b0;
        end
      endcase
    end
  end

  // Bus value per state; WDATA passes the offered byte straight through so a
  // legal byte appears on the bus in the same cycle it is consumed.
  always_comb begin
    bus_drive = 8'h00;
    case (state_q)
      HDR:     bus_drive = write_q ? 8'hFF : 8'h00;
      WDATA:   bus_drive = wr_legal ? wr_data_i : 8'hFF;
      RSTB:    bus_drive = 8'h01;
      default: bus_drive = 8'h00;
    endcase
  end

  // Release the bus in exactly the cycles the memory is told to drive it.
  assign mem_data_io = oe_q ? 8'hzz : bus_drive;

  assign cmd_ready_o = cmd_ready_q;
  assign wr_ready_o  = wr_ready_q;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign mem_tx_oe_o = oe_q;

endmodule

// File: doc/mem_bus_sequencer.md
# mem_bus_sequencer

Host-side stage that drives the shared 8-bit memory bus and its direction control on behalf of the USB-facing logic. It accepts write or read burst commands over a valid/ready interface and serialises them into the memory byte protocol: 0xFF header for write mode, 0x00 header for read mode, then payload or strobe bytes. It owns the bus except during read capture cycles, when it raises the output-enable so the memory drives the bus and registers the returned byte.

## Interface
Parameters:
- MAX_LEN, 5, memory depth in bytes; largest legal burst length.

Ports:
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid and ready are both high.
- cmd_write_i  in  1  1 = write burst, 0 = read burst.
- cmd_len_i  in  3  burst length in bytes; legal range 1..MAX_LEN.
- wr_data_i  in  8  write payload byte.
- wr_valid_i  in  1  payload byte present.
- wr_ready_o  out  1  payload byte consumed when valid and ready are both high.
- rd_data_o  out  8  captured read byte.
- rd_valid_o  out  1  one-cycle pulse; rd_data_o is valid. No backpressure.
- done_o  out  1  one-cycle pulse at burst completion.
- err_o  out  1  one-cycle pulse on an illegal length or an illegal payload byte.
- mem_data_io  inout  8  memory bus; driven by this block while mem_tx_oe_o = 0, high-Z while mem_tx_oe_o = 1.
- mem_tx_oe_o  out  1  1 = memory drives the bus.

## Operation
- States: IDLE, HDR, WDATA, RSTB, RCAP, DONE.
- Bus drive value per state:
  - IDLE = 0x00.
  - HDR = 0xFF for a write, 0x00 for a read.
  - WDATA = accepted byte, or 0xFF on a stall cycle. 0xFF re-asserts write mode and does not advance the memory.
  - RSTB = 0x01.
  - RCAP = released.
  - DONE = 0x00.
- IDLE:
  - cmd_ready_o = 1.
  - On accept, latch direction and length and clear the beat counter.
  - If cmd_len_i = 0 or cmd_len_i > MAX_LEN: pulse err_o the next cycle, stay in IDLE, no bus activity.
  - Otherwise go to HDR.
- HDR: lasts one cycle, then goes to WDATA (write) or RSTB (read).
- WDATA:
  - wr_ready_o = 1.
  - Legal byte (not 0x00 or 0xFF): drive it this cycle and increment the beat counter.
  - Illegal byte (0x00 or 0xFF): consume it, drive 0xFF, do not count it, pulse err_o the next cycle.
  - When beat count = latched length, go to DONE.
- RSTB: lasts one cycle, then goes to RCAP.
- RCAP:
  - mem_tx_oe_o = 1.
  - Sample mem_data_io into rd_data_o at the rising edge that ends RCAP; pulse rd_valid_o the following cycle.
  - Increment the beat counter. Go to RSTB if beats remain, else to DONE.
- DONE: pulse done_o, then return to IDLE.
- wr_ready_o is 0 outside WDATA; cmd_ready_o is 0 outside IDLE.
- Beat counter is 3 bits and never wraps, because the length is checked on accept.

## Timing
- Reset values: cmd_ready_o = 1, wr_ready_o = 0, rd_data_o = 0x00, rd_valid_o = 0, done_o = 0, err_o = 0, mem_tx_oe_o = 0, bus driven 0x00, state IDLE.
- Reset asserted mid-burst: aborts immediately (asynchronous). No done_o and no further rd_valid_o pulses.
- Write burst of N bytes with no stalls: accept at cycle 0, HDR at cycle 1, payload at cycles 2..N+1, done_o at cycle N+2. Each stall cycle adds one cycle.
- Read burst of N bytes:
  - HDR at cycle 1.
  - Beat k (k = 0..N-1): RSTB at cycle 2+2k, RCAP at cycle 3+2k, rd_valid_o at cycle 4+2k.
  - done_o at cycle 2N+2, coincident with the last rd_valid_o.
- Bus turnaround: mem_tx_oe_o changes only on RSTB→RCAP and RCAP→(RSTB|DONE). The block releases the bus in the same cycle mem_tx_oe_o rises.
- cmd_valid_i while busy is ignored and remains pending until IDLE.
- Back-to-back commands: the next accept occurs in the IDLE cycle after DONE, so the minimum gap is one IDLE cycle driving 0x00.

## Test plan
- Write, length 3, payload 0x11, 0x22, 0x33, wr_valid_i held high → bus sequence 0x00, 0xFF, 0x11, 0x22, 0x33, 0x00; done_o at cycle 5.
- Write, length 2, with wr_valid_i low for 2 cycles before the second byte 0x44 → bus shows 0xFF during the stall, then 0x44; done_o delayed by 2 cycles; no err_o.
- Write, length 2, payload 0xFF, 0x55, 0x66 → err_o pulses once, 0x55 and 0x66 are written, done_o after the second legal byte.
- Read, length 5, memory model returning 0xA1..0xA5 → five rd_valid_o pulses with 0xA1..0xA5 at cycles 4, 6, 8, 10, 12; mem_tx_oe_o high only in RCAP cycles; no bus contention.
- Command with cmd_len_i = 0, then a command with cmd_len_i = 6 → err_o pulse for each, bus stays 0x00, no done_o.
- Read, length 4, rst_i asserted during the second RCAP → all outputs return to reset values asynchronously; a following write of length 1 completes normally.
